// File: rtl/jtag_host_shifter.sv
// JTAG initiator: walks an 1149.1 TAP through IR/DR scans and returns the captured TDO bits.
// Latency: (6+IR_WIDTH) or (5+DR_WIDTH) TCK periods of 2*CLK_DIV clk, then rsp_valid one clk later.
// Backpressure: cmd_ready is low from acceptance until rsp_valid; the response cannot be stalled.
module jtag_host_shifter #(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 32,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                tl_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_is_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(DR_WIDTH) + 1;
  // Wide enough for the five reset periods even with a tiny DR_WIDTH.
  localparam int CW = (BW < 3) ? 3 : BW;

  localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_FALL  = PW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(4);
  localparam logic [CW-1:0] IR_LAST  = CW'(IR_WIDTH - 1);
  localparam logic [CW-1:0] DR_LAST  = CW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    RST_SEQ,
    ENTER_IDLE,
    IDLE,
    HDR,
    SHIFT,
    POST,
    DONE
  } state_t;

  typedef struct packed {
    logic                is_ir;
    logic [DR_WIDTH-1:0] dat;
  } cmd_t;

  state_t              state;
  logic [PW-1:0]       ph;
  logic [CW-1:0]       cnt;
  cmd_t                cmd;
  logic [DR_WIDTH-1:0] cap;

  logic                ph_active;
  logic                at_rise;
  logic                at_fall;
  logic [CW-1:0]       cnt_nxt;
  logic [CW-1:0]       hdr_last;
  logic [CW-1:0]       hdr_ones;
  logic [CW-1:0]       shift_last;
  logic [DR_WIDTH-1:0] cap_aligned;

  assign ph_active  = (state == RST_SEQ) || (state == ENTER_IDLE) || (state == HDR) ||
                      (state == SHIFT)   || (state == POST);
  assign at_rise    = ph_active && (ph == PH_RISE);
  assign at_fall    = ph_active && (ph == PH_FALL);
  assign cnt_nxt    = cnt + CW'(1);
  assign hdr_last   = cmd.is_ir ? CW'(3) : CW'(2);
  assign hdr_ones   = cmd.is_ir ? CW'(2) : CW'(1);
  assign shift_last = cmd.is_ir ? IR_LAST : DR_LAST;

  // TDO bits enter at the top, so a short IR capture sits in the upper bits until realigned.
  assign cap_aligned = cmd.is_ir ? (cap >> (DR_WIDTH - IR_WIDTH)) : cap;

  always_ff @(posedge clk or posedge tl_reset) begin
    if (tl_reset) begin
      state     <= RST_SEQ;
      ph        <= '0;
      cnt       <= '0;
      cmd       <= '0;
      cap       <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;

      if (ph_active) begin
        ph <= at_fall ? '0 : ph + PW'(1);
        if (at_rise) begin
          tck <= 1'b1;
          if (state == SHIFT) begin
            cap <= {tdo, cap[DR_WIDTH-1:1]};
          end
        end
      end

      // Every period boundary (at_fall) drops tck and presents the next tms/tdi.
      case (state)
        RST_SEQ: begin
          if (at_fall) begin
            tck <= 1'b0;
            if (cnt == RST_LAST) begin
              cnt   <= '0;
              tms   <= 1'b0;
              state <= ENTER_IDLE;
            end else begin
              cnt <= cnt_nxt;
              tms <= 1'b1;
            end
          end
        end

        ENTER_IDLE: begin
          if (at_fall) begin
            tck       <= 1'b0;
            tms       <= 1'b0;
            tdi       <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cmd       <= '{is_ir: cmd_is_ir, dat: cmd_data};
            cap       <= '0;
            cnt       <= '0;
            ph        <= '0;
            tms       <= 1'b1;
            state     <= HDR;
          end
        end

        HDR: begin
          if (at_fall) begin
            tck <= 1'b0;
            if (cnt == hdr_last) begin
              cnt   <= '0;
              tms   <= 1'b0;
              tdi   <= cmd.dat[0];
              state <= SHIFT;
            end else begin
              cnt <= cnt_nxt;
              tms <= (cnt_nxt < hdr_ones);
            end
          end
        end

        SHIFT: begin
          if (at_fall) begin
            tck <= 1'b0;
            if (cnt == shift_last) begin
              cnt   <= '0;
              tms   <= 1'b1;
              tdi   <= 1'b0;
              state <= POST;
            end else begin
              cnt     <= cnt_nxt;
              tdi     <= cmd.dat[1];
              cmd.dat <= cmd.dat >> 1;
              tms     <= (cnt_nxt == shift_last);
            end
          end
        end

        POST: begin
          if (at_fall) begin
            tck <= 1'b0;
            if (cnt == CW'(1)) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt_nxt;
              tms <= 1'b0;
            end
          end
        end

        DONE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= cap_aligned;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= RST_SEQ;
      endcase
    end
  end

endmodule
